// File: rtl/pipe_ctrl_pkg.sv
// Shared types and width defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: one cycle from inc to count, holds at all-ones.
// No backpressure; inc is sampled every cycle.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are combinational
// from the state register and inputs. A redirect survives imem wait states.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_MEM_READ,
  input  logic                  EX_BRANCH_TAKEN,
  input  logic [WIDTH-1:0]      EX_TARGET,
  input  logic                  IMEM_READY,
  input  logic                  DMEM_READY,
  output logic                  PC_WRITE,
  output logic                  PC_SEL,
  output logic [WIDTH-1:0]      PC_TARGET,
  output logic                  IF_ID_STALL,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_FLUSH,
  output logic                  PIPE_FREEZE,
  output logic [CNT_W-1:0]      STALL_CNT,
  output logic [CNT_W-1:0]      FLUSH_CNT
);

  hz_state_t        state, state_nxt;
  logic [WIDTH-1:0] pend_target;
  logic             latch_target;
  logic             flush_inc;
  logic             stall_inc;
  logic             load_use;

  assign load_use = EX_MEM_READ && (EX_RD != '0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  always_comb begin
    PC_WRITE     = 1'b0;
    PC_SEL       = 1'b0;
    PC_TARGET    = EX_TARGET;
    IF_ID_STALL  = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    PIPE_FREEZE  = 1'b0;
    state_nxt    = state;
    latch_target = 1'b0;
    flush_inc    = 1'b0;

    if (rst) begin
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
      state_nxt   = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!DMEM_READY) begin
            PIPE_FREEZE = 1'b1;
            IF_ID_STALL = 1'b1;
          end else if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
            PC_SEL      = 1'b1;
            flush_inc   = 1'b1;
            if (IMEM_READY) begin
              PC_WRITE = 1'b1;
            end else begin
              latch_target = 1'b1;
              state_nxt    = REDIR_WAIT;
            end
          end else if (load_use) begin
            IF_ID_STALL = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (!IMEM_READY) begin
            IF_ID_FLUSH = 1'b1;
          end else begin
            PC_WRITE = 1'b1;
          end
        end
        REDIR_WAIT: begin
          // EX holds the bubble from the original redirect, so a branch here is stale.
          PC_SEL      = 1'b1;
          PC_TARGET   = pend_target;
          IF_ID_FLUSH = 1'b1;
          if (!DMEM_READY) begin
            PIPE_FREEZE = 1'b1;
          end else if (IMEM_READY) begin
            PC_WRITE  = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pend_target <= '0;
    end else begin
      state <= state_nxt;
      if (latch_target) begin
        pend_target <= EX_TARGET;
      end
    end
  end

  assign stall_inc = !rst && !PC_WRITE;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (STALL_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (FLUSH_CNT)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, corner sequences, random vs rule model.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic        rst;
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        bt;
    logic [31:0] tgt;
    logic        imem;
    logic        dmem;
  } vin_t;

  typedef struct {
    logic pw, ps, st, fl, ix, fz;
  } vout_t;

  typedef struct {
    vin_t  i;
    vout_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic [31:0] ex_target;
  logic        imem_ready, dmem_ready;

  logic        pc_write, pc_sel, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze;
  logic [31:0] pc_target;
  logic [15:0] stall_cnt, flush_cnt;

  logic        pc_write4, pc_sel4, if_id_stall4, if_id_flush4, id_ex_flush4, pipe_freeze4;
  logic [31:0] pc_target4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  // Reference state: whether a redirect is outstanding, its target, and event tallies.
  bit          m_redir;
  logic [31:0] m_tgt;
  int          m_stall, m_flush;
  vout_t       last_o;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .EX_RD(ex_rd), .EX_MEM_READ(ex_mem_read), .EX_BRANCH_TAKEN(ex_branch_taken),
    .EX_TARGET(ex_target), .IMEM_READY(imem_ready), .DMEM_READY(dmem_ready),
    .PC_WRITE(pc_write), .PC_SEL(pc_sel), .PC_TARGET(pc_target),
    .IF_ID_STALL(if_id_stall), .IF_ID_FLUSH(if_id_flush), .ID_EX_FLUSH(id_ex_flush),
    .PIPE_FREEZE(pipe_freeze), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .EX_RD(ex_rd), .EX_MEM_READ(ex_mem_read), .EX_BRANCH_TAKEN(ex_branch_taken),
    .EX_TARGET(ex_target), .IMEM_READY(imem_ready), .DMEM_READY(dmem_ready),
    .PC_WRITE(pc_write4), .PC_SEL(pc_sel4), .PC_TARGET(pc_target4),
    .IF_ID_STALL(if_id_stall4), .IF_ID_FLUSH(if_id_flush4), .ID_EX_FLUSH(id_ex_flush4),
    .PIPE_FREEZE(pipe_freeze4), .STALL_CNT(stall_cnt4), .FLUSH_CNT(flush_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vin_t vi(input logic r, input logic mr, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic bt, input logic [31:0] tgt,
                              input logic imem, input logic dmem);
    vin_t v;
    v.rst = r; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.bt = bt; v.tgt = tgt; v.imem = imem; v.dmem = dmem;
    return v;
  endfunction

  function automatic vin_t idle();
    return vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1);
  endfunction

  function automatic vec_t mk(input vin_t i, input logic [5:0] o);
    vec_t r;
    r.i = i;
    {r.o.pw, r.o.ps, r.o.st, r.o.fl, r.o.ix, r.o.fz} = o;
    return r;
  endfunction

  function automatic int sat(input int v, input int bits);
    int mx;
    mx = (1 << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected controls straight from the priority rules.
  function automatic vout_t model_out(input vin_t v);
    vout_t o;
    bit hit1, hit2, lu;
    o = '{default: 1'b0};
    hit1 = v.u1 && (v.rs1 == v.rd);
    hit2 = v.u2 && (v.rs2 == v.rd);
    lu   = v.mr && (v.rd != 0) && (hit1 || hit2);
    if (v.rst) begin
      o.fl = 1; o.ix = 1;
    end else if (m_redir) begin
      o.ps = 1; o.fl = 1;
      o.fz = !v.dmem;
      o.pw = v.dmem && v.imem;
    end else if (!v.dmem) begin
      o.fz = 1; o.st = 1;
    end else if (v.bt) begin
      o.fl = 1; o.ix = 1; o.ps = 1; o.pw = v.imem;
    end else if (lu) begin
      o.st = 1; o.ix = 1;
    end else if (!v.imem) begin
      o.fl = 1;
    end else begin
      o.pw = 1;
    end
    return o;
  endfunction

  task automatic apply(input vin_t v);
    rst = v.rst; ex_mem_read = v.mr; ex_rd = v.rd;
    id_rs1 = v.rs1; id_uses_rs1 = v.u1; id_rs2 = v.rs2; id_uses_rs2 = v.u2;
    ex_branch_taken = v.bt; ex_target = v.tgt; imem_ready = v.imem; dmem_ready = v.dmem;
  endtask

  task automatic step(input vin_t v, input string tag);
    vout_t e;
    @(negedge clk);
    apply(v);
    #1;
    e = model_out(v);
    last_o = '{pw: pc_write, ps: pc_sel, st: if_id_stall, fl: if_id_flush,
               ix: id_ex_flush, fz: pipe_freeze};
    chk({tag, ".pc_write"},    {31'b0, pc_write},    {31'b0, e.pw});
    chk({tag, ".pc_sel"},      {31'b0, pc_sel},      {31'b0, e.ps});
    chk({tag, ".if_id_stall"}, {31'b0, if_id_stall}, {31'b0, e.st});
    chk({tag, ".if_id_flush"}, {31'b0, if_id_flush}, {31'b0, e.fl});
    chk({tag, ".id_ex_flush"}, {31'b0, id_ex_flush}, {31'b0, e.ix});
    chk({tag, ".pipe_freeze"}, {31'b0, pipe_freeze}, {31'b0, e.fz});
    chk({tag, ".pc_write4"},   {31'b0, pc_write4},   {31'b0, e.pw});
    if (e.ps && !v.rst) chk({tag, ".pc_target"}, pc_target, m_redir ? m_tgt : v.tgt);
    @(posedge clk);
    if (v.rst) begin
      m_redir = 0; m_tgt = '0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e.pw) m_stall++;
      if (!m_redir && v.dmem && v.bt) begin
        m_flush++;
        if (!v.imem) begin
          m_redir = 1; m_tgt = v.tgt;
        end
      end else if (m_redir && v.dmem && v.imem) begin
        m_redir = 0;
      end
    end
    #1;
    chk({tag, ".stall_cnt"},  {16'b0, stall_cnt},  sat(m_stall, 16));
    chk({tag, ".flush_cnt"},  {16'b0, flush_cnt},  sat(m_flush, 16));
    chk({tag, ".stall_cnt4"}, {28'b0, stall_cnt4}, sat(m_stall, 4));
    chk({tag, ".flush_cnt4"}, {28'b0, flush_cnt4}, sat(m_flush, 4));
  endtask

  vec_t tbl[13];
  vin_t v;

  initial begin
    m_redir = 0; m_tgt = '0; m_stall = 0; m_flush = 0;
    apply(idle());

    // Outputs bits: {pw, ps, st, fl, ix, fz}; every entry starts and ends in RUN.
    tbl[0]  = mk(vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 1), 6'b100000);
    tbl[1]  = mk(vi(0, 1, 3, 3, 1, 0, 0, 0, 32'h0,  1, 1), 6'b001010);
    tbl[2]  = mk(vi(0, 1, 3, 3, 0, 0, 0, 0, 32'h0,  1, 1), 6'b100000);
    tbl[3]  = mk(vi(0, 1, 0, 0, 0, 0, 1, 0, 32'h0,  1, 1), 6'b100000);
    tbl[4]  = mk(vi(0, 1, 5, 0, 0, 5, 1, 0, 32'h0,  1, 1), 6'b001010);
    tbl[5]  = mk(vi(0, 0, 5, 0, 0, 5, 1, 0, 32'h0,  1, 1), 6'b100000);
    tbl[6]  = mk(vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1), 6'b000100);
    tbl[7]  = mk(vi(0, 1, 7, 7, 1, 0, 0, 0, 32'h0,  0, 1), 6'b001010);
    tbl[8]  = mk(vi(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 1), 6'b110110);
    tbl[9]  = mk(vi(0, 1, 2, 2, 1, 0, 0, 1, 32'h44, 1, 1), 6'b110110);
    tbl[10] = mk(vi(0, 1, 2, 2, 1, 0, 0, 1, 32'h48, 1, 0), 6'b001001);
    tbl[11] = mk(vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0), 6'b001001);
    tbl[12] = mk(vi(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 1), 6'b000110);

    // Reset for two cycles, then a clean run cycle.
    step(vi(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1), "reset0");
    step(vi(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1), "reset1");
    chk("reset.flush_cnt", {16'b0, flush_cnt}, 0);
    step(idle(), "post_reset");
    chk("post_reset.pc_write", {31'b0, last_o.pw}, 1);

    for (int k = 0; k < 13; k++) begin
      step(tbl[k].i, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.outs", k),
          {26'b0, last_o.pw, last_o.ps, last_o.st, last_o.fl, last_o.ix, last_o.fz},
          {26'b0, tbl[k].o.pw, tbl[k].o.ps, tbl[k].o.st, tbl[k].o.fl, tbl[k].o.ix, tbl[k].o.fz});
    end

    // Load-use bubble lasts one cycle once the load moves on.
    step(vi(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1), "seq_rst");
    step(vi(0, 1, 5, 0, 0, 5, 1, 0, 32'h0, 1, 1), "lu");
    step(vi(0, 0, 9, 0, 0, 5, 1, 0, 32'h0, 1, 1), "lu_after");
    chk("lu.stall_cnt_is_1", {16'b0, stall_cnt}, 1);

    // Taken branch with fetch ready, then one that must wait out three imem stalls.
    step(vi(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 1), "br40");
    chk("br40.flush_cnt", {16'b0, flush_cnt}, 1);
    step(vi(0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 1), "br80_0");
    step(vi(0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 1), "br80_1");
    chk("br80_1.target_held", pc_target, 32'h80);
    step(vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1), "br80_2");
    step(vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1), "br80_go");
    chk("br80_go.pc_write", {31'b0, last_o.pw}, 1);
    chk("br80_go.pc_sel", {31'b0, last_o.ps}, 1);
    chk("br80.stall_cnt", {16'b0, stall_cnt}, 4);
    chk("br80.flush_cnt", {16'b0, flush_cnt}, 2);

    // Data-memory wait masks branch and load-use, then the branch goes through.
    step(vi(0, 1, 6, 6, 1, 0, 0, 1, 32'hC0, 1, 0), "dmem_hold");
    chk("dmem_hold.freeze", {31'b0, last_o.fz}, 1);
    chk("dmem_hold.flush_cnt", {16'b0, flush_cnt}, 2);
    step(vi(0, 1, 6, 6, 1, 0, 0, 1, 32'hC0, 1, 1), "dmem_go");
    chk("dmem_go.pc_sel", {31'b0, last_o.ps}, 1);
    chk("dmem_go.flush_cnt", {16'b0, flush_cnt}, 3);

    // Data-memory wait while a redirect is pending.
    step(vi(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 1), "rw_enter");
    step(vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0), "rw_freeze");
    chk("rw_freeze.flush_not_stall", {30'b0, last_o.fl, last_o.st}, 32'h2);
    step(vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1), "rw_exit");
    chk("rw_exit.target", pc_target, 32'h0);

    // Saturation of the 4-bit build, then reset while a redirect is pending.
    step(vi(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1), "sat_rst");
    for (int k = 0; k < 20; k++) step(vi(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1), "sat");
    chk("sat.stall_cnt4", {28'b0, stall_cnt4}, 32'hF);
    chk("sat.stall_cnt", {16'b0, stall_cnt}, 20);
    step(vi(0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 1), "rst_rw_enter");
    step(vi(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1), "rst_rw");
    chk("rst_rw.stall_cnt", {16'b0, stall_cnt}, 0);
    step(idle(), "rst_rw_after");
    chk("rst_rw_after.run", {30'b0, last_o.pw, last_o.ps}, 32'h2);

    // Random traffic against the rule model.
    for (int k = 0; k < 400; k++) begin
      v = vi(($urandom % 60) == 0, $urandom % 2, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom % 2, 5'($urandom_range(0, 3)), $urandom % 2,
             ($urandom % 4) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 5) != 0);
      step(v, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
